// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC and instruction register ahead of decode.
// Drives the ROM address and hands fetched words over valid/ready.
module fetch_sequencer #(
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 16,
    parameter logic [3:0]  HALT_OP = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              restart,
    output logic              halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] ir_n;
    logic [ADDR_W-1:0] ir_pc_n;
    logic              ir_valid_n;
    logic              is_halt;
    logic              can_load;

    assign is_halt  = (rom_data[DATA_W-1 -: 4] == HALT_OP);
    assign can_load = !ir_valid || ir_ready;

    // State, PC and instruction register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ir       <= ir_n;
            ir_pc    <= ir_pc_n;
            ir_valid <= ir_valid_n;
        end
    end

    // Next state: restart beats branch, branch beats load/stall.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ir_n       = ir;
        ir_pc_n    = ir_pc;
        ir_valid_n = ir_valid;
        if (restart) begin
            state_n    = FETCH;
            pc_n       = '0;
            ir_valid_n = 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (branch_en) begin
                        pc_n       = branch_target;
                        ir_valid_n = 1'b0;
                    end else if (can_load) begin
                        ir_n       = rom_data;
                        ir_pc_n    = pc;
                        ir_valid_n = 1'b1;
                        if (is_halt) begin
                            state_n = HALT;
                        end else begin
                            pc_n = pc + ADDR_W'(1);
                        end
                    end
                end
                HALT: begin
                    if (ir_valid && ir_ready) begin
                        ir_valid_n = 1'b0;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    assign rom_addr = pc;
    assign halted   = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks for fetch_sequencer.
// ROM model holds 16'h1000 + i, with a halt word at address 6.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] ir;
    logic [3:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        branch_en;
    logic [3:0]  branch_target;
    logic        restart;
    logic        halted;

    logic [15:0] mem [16];

    int n_cmp;
    int n_bad;

    fetch_sequencer #(
        .ADDR_W (4),
        .DATA_W (16),
        .HALT_OP(4'hF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .restart      (restart),
        .halted       (halted)
    );

    assign rom_data = mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
        mem[6] = 16'hF000;
        rst_n         = 1'b0;
        ir_ready      = 1'b0;
        branch_en     = 1'b0;
        branch_target = 4'd0;
        restart       = 1'b0;
        #1;
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_valid", 32'(ir_valid), 32'h0);
        chk("rst_addr", 32'(rom_addr), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        step();
        step();
        rst_n    = 1'b1;
        ir_ready = 1'b1;
        chk("rel_valid", 32'(ir_valid), 32'h0);

        // streaming up to the halt word
        for (int i = 0; i < 6; i++) begin
            step();
            chk("str_ir", 32'(ir), 32'h1000 + 32'(i));
            chk("str_pc", 32'(ir_pc), 32'(i));
            chk("str_valid", 32'(ir_valid), 32'h1);
            chk("str_addr", 32'(rom_addr), 32'(i + 1));
            chk("str_halted", 32'(halted), 32'h0);
        end
        step();
        chk("hlt_ir", 32'(ir), 32'hF000);
        chk("hlt_pc", 32'(ir_pc), 32'h6);
        chk("hlt_halted", 32'(halted), 32'h1);
        chk("hlt_addr", 32'(rom_addr), 32'h6);
        step();
        chk("hlt_xfer", 32'(ir_valid), 32'h0);
        chk("hlt_keep", 32'(ir), 32'hF000);

        // branch ignored while halted
        branch_en     = 1'b1;
        branch_target = 4'd3;
        step();
        branch_en = 1'b0;
        chk("hbr_addr", 32'(rom_addr), 32'h6);
        chk("hbr_halted", 32'(halted), 32'h1);
        chk("hbr_valid", 32'(ir_valid), 32'h0);

        // restart
        do_restart();
        chk("rs_halted", 32'(halted), 32'h0);
        chk("rs_valid", 32'(ir_valid), 32'h0);
        chk("rs_addr", 32'(rom_addr), 32'h0);
        step();
        chk("rs_ir", 32'(ir), 32'h1000);
        chk("rs_pc", 32'(ir_pc), 32'h0);

        // back-pressure on 1002
        step();
        step();
        chk("bp_ir0", 32'(ir), 32'h1002);
        ir_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_ir", 32'(ir), 32'h1002);
            chk("bp_pc", 32'(ir_pc), 32'h2);
            chk("bp_valid", 32'(ir_valid), 32'h1);
            chk("bp_addr", 32'(rom_addr), 32'h3);
        end
        ir_ready = 1'b1;
        step();
        chk("bp_next", 32'(ir), 32'h1003);
        chk("bp_next_pc", 32'(ir_pc), 32'h3);

        // branch with ir_ready low, then high
        for (int r = 0; r < 2; r++) begin
            ir_ready = 1'b1;
            do_restart();
            step();
            step();
            chk("br_pre", 32'(ir), 32'h1001);
            ir_ready      = (r == 1);
            branch_en     = 1'b1;
            branch_target = 4'd4;
            step();
            branch_en = 1'b0;
            chk("br_bubble", 32'(ir_valid), 32'h0);
            chk("br_addr", 32'(rom_addr), 32'h4);
            step();
            chk("br_ir", 32'(ir), 32'h1004);
            chk("br_pc", 32'(ir_pc), 32'h4);
            chk("br_valid", 32'(ir_valid), 32'h1);
        end

        // wrap-around with no halt word
        mem[6]        = 16'h1006;
        ir_ready      = 1'b1;
        branch_en     = 1'b1;
        branch_target = 4'd14;
        step();
        branch_en = 1'b0;
        chk("wr_bubble", 32'(ir_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'(14 + i);
            step();
            chk("wr_pc", 32'(ir_pc), 32'(a));
            chk("wr_ir", 32'(ir), 32'h1000 + 32'(a));
        end
        chk("wr_addr", 32'(rom_addr), 32'h2);

        // asynchronous reset between edges
        chk("ar_pre", 32'(ir_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ir", 32'(ir), 32'h0);
        chk("ar_pc", 32'(ir_pc), 32'h0);
        chk("ar_valid", 32'(ir_valid), 32'h0);
        chk("ar_addr", 32'(rom_addr), 32'h0);
        chk("ar_halted", 32'(halted), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
